// File: rtl/fwd_pkg.sv
// Shared definitions for the E-stage forwarding / scoreboard controller.
//   REG_IDX_W : register index width (5 for 32 registers per file)
//   RF_INT/RF_FP : register-file selector values
//   writer_t  : a result producer (wb enable, file, index)
//   match()   : writer-vs-register comparison with the int x0 exclusion built in
package fwd_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam logic RF_INT = 1'b0;
  localparam logic RF_FP  = 1'b1;

  typedef struct packed {
    logic                 wb_en;
    logic                 fp;
    logic [REG_IDX_W-1:0] idx;
  } writer_t;

  // Int x0 is hard-wired zero, so nothing ever matches it; fp f0 is ordinary.
  function automatic logic match(writer_t w, logic fp, logic [REG_IDX_W-1:0] idx);
    return w.wb_en && (w.fp == fp) && (w.idx == idx) &&
           !((fp == RF_INT) && (idx == '0));
  endfunction

endpackage

// File: rtl/fwd_src_resolve.sv
// Resolves one E-stage source operand.
//   used/fp/idx/rf_data : source descriptor and register-file read data
//   busy                : scoreboard bit for this source's register
//   m_wr/m_fwd_ok/m_data: M-stage writer, availability and result
//   w_wr/w_data         : W-stage writer and result
//   l_wr/l_data         : long-op completion port
//   data                : forwarded operand, priority L > M > W > RF
//   raw_long            : source waits on a pending long op not completing now
//   load_use            : source needs an M result that is not yet available
module fwd_src_resolve
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                 used,
  input  logic                 fp,
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [XLEN-1:0]      rf_data,
  input  logic                 busy,
  input  writer_t              m_wr,
  input  logic                 m_fwd_ok,
  input  logic [XLEN-1:0]      m_data,
  input  writer_t              w_wr,
  input  logic [XLEN-1:0]      w_data,
  input  writer_t              l_wr,
  input  logic [XLEN-1:0]      l_data,
  output logic [XLEN-1:0]      data,
  output logic                 raw_long,
  output logic                 load_use
);

  logic l_hit;
  logic m_hit;
  logic w_hit;
  logic is_x0;

  always_comb begin
    is_x0 = (fp == RF_INT) && (idx == '0);
    l_hit = used && match(l_wr, fp, idx);
    m_hit = used && match(m_wr, fp, idx);
    w_hit = used && match(w_wr, fp, idx);

    data = rf_data;
    if (l_hit)      data = l_data;
    else if (m_hit) data = m_data;
    else if (w_hit) data = w_data;

    raw_long = used && !is_x0 && busy && !l_hit;
    load_use = m_hit && !m_fwd_ok;
  end

endmodule

// File: rtl/fwd_sb_ctlr.sv
// E-stage operand forwarding and hazard controller with a long-latency
// scoreboard covering both the int and fp register files.
//   i_E_*        : E-stage instruction (sources, destination, long flag)
//   i_flush      : kills the E instruction this cycle
//   i_M_*/i_W_*  : M and W stage writers for bypass
//   i_L_*        : long-op completion port
//   o_src_data   : resolved operands, NSRC x XLEN (combinational)
//   o_stall      : RAW-long, load-use, WAW or scoreboard-full hazard
//   o_out_cnt    : outstanding long ops
//   o_sb_empty   : no long op pending
//   o_err        : sticky, completion seen on a non-busy register
module fwd_sb_ctlr
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned NSRC    = 3,
  parameter int unsigned MAX_OUT = 4,
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_E_valid,
  input  logic [NSRC-1:0]           i_E_src_used,
  input  logic [NSRC-1:0]           i_E_src_fp,
  input  logic [NSRC*REG_IDX_W-1:0] i_E_src_idx,
  input  logic [NSRC*XLEN-1:0]      i_E_src_data,
  input  logic                      i_E_wb_en,
  input  logic                      i_E_rd_fp,
  input  logic [REG_IDX_W-1:0]      i_E_rd_idx,
  input  logic                      i_E_long,
  input  logic                      i_flush,
  input  logic                      i_M_wb_en,
  input  logic                      i_M_rd_fp,
  input  logic [REG_IDX_W-1:0]      i_M_rd_idx,
  input  logic                      i_M_fwd_ok,
  input  logic [XLEN-1:0]           i_M_fwd_data,
  input  logic                      i_W_wb_en,
  input  logic                      i_W_rd_fp,
  input  logic [REG_IDX_W-1:0]      i_W_rd_idx,
  input  logic [XLEN-1:0]           i_W_wb_data,
  input  logic                      i_L_valid,
  input  logic                      i_L_rd_fp,
  input  logic [REG_IDX_W-1:0]      i_L_rd_idx,
  input  logic [XLEN-1:0]           i_L_data,
  output logic [NSRC*XLEN-1:0]      o_src_data,
  output logic                      o_stall,
  output logic [CNT_W-1:0]          o_out_cnt,
  output logic                      o_sb_empty,
  output logic                      o_err
);

  logic [NREG-1:0]  busy_q [2];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             err_q;

  writer_t m_wr;
  writer_t w_wr;
  writer_t l_wr;

  logic [NSRC-1:0] raw_long;
  logic [NSRC-1:0] load_use;

  logic l_x0, l_busy, l_done, l_err;
  logic rd_x0, rd_busy, waw, full;
  logic issue, set_busy;

  always_comb begin
    m_wr = '{wb_en: i_M_wb_en, fp: i_M_rd_fp, idx: i_M_rd_idx};
    w_wr = '{wb_en: i_W_wb_en, fp: i_W_rd_fp, idx: i_W_rd_idx};
    l_wr = '{wb_en: i_L_valid, fp: i_L_rd_fp, idx: i_L_rd_idx};
  end

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    fwd_src_resolve #(.XLEN(XLEN)) u_resolve (
      .used     (i_E_src_used[k]),
      .fp       (i_E_src_fp[k]),
      .idx      (i_E_src_idx[k*REG_IDX_W +: REG_IDX_W]),
      .rf_data  (i_E_src_data[k*XLEN +: XLEN]),
      .busy     (busy_q[i_E_src_fp[k]][i_E_src_idx[k*REG_IDX_W +: REG_IDX_W]]),
      .m_wr     (m_wr),
      .m_fwd_ok (i_M_fwd_ok),
      .m_data   (i_M_fwd_data),
      .w_wr     (w_wr),
      .w_data   (i_W_wb_data),
      .l_wr     (l_wr),
      .l_data   (i_L_data),
      .data     (o_src_data[k*XLEN +: XLEN]),
      .raw_long (raw_long[k]),
      .load_use (load_use[k])
    );
  end

  always_comb begin
    l_x0    = (i_L_rd_fp == RF_INT) && (i_L_rd_idx == '0);
    l_busy  = busy_q[i_L_rd_fp][i_L_rd_idx];
    l_done  = i_L_valid && !l_x0 && l_busy;
    l_err   = i_L_valid && !l_x0 && !l_busy;

    rd_x0   = (i_E_rd_fp == RF_INT) && (i_E_rd_idx == '0);
    rd_busy = busy_q[i_E_rd_fp][i_E_rd_idx] && !rd_x0;
    // A busy rd that completes this very cycle is free at the same edge.
    waw     = i_E_wb_en && rd_busy &&
              !(l_done && (i_L_rd_fp == i_E_rd_fp) && (i_L_rd_idx == i_E_rd_idx));
    full    = i_E_long && (cnt_q == CNT_W'(MAX_OUT)) && !l_done;

    o_stall  = i_E_valid && ((|raw_long) || (|load_use) || waw || full);
    issue    = i_E_valid && !o_stall && !i_flush;
    set_busy = issue && i_E_long && i_E_wb_en && !rd_x0;

    cnt_next = cnt_q;
    if (set_busy && !l_done)      cnt_next = cnt_q + CNT_W'(1);
    else if (!set_busy && l_done) cnt_next = cnt_q - CNT_W'(1);
  end

  // Clear before set so a same-register issue/completion pair ends busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q[0] <= '0;
      busy_q[1] <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (l_done)   busy_q[i_L_rd_fp][i_L_rd_idx] <= 1'b0;
      if (set_busy) busy_q[i_E_rd_fp][i_E_rd_idx] <= 1'b1;
      if (l_err)    err_q <= 1'b1;
      cnt_q <= cnt_next;
    end
  end

  always_comb begin
    o_out_cnt  = cnt_q;
    o_sb_empty = (cnt_q == '0);
    o_err      = err_q;
  end

endmodule

// File: tb/tb_fwd_sb_ctlr.sv
// Self-checking bench for fwd_sb_ctlr: directed scenarios plus a randomized
// run against a behavioural scoreboard model.
module tb_fwd_sb_ctlr;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NSRC = 3;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            E_valid, E_wb_en, E_rd_fp, E_long, flush;
  logic [4:0]      E_rd_idx;
  logic [NSRC-1:0] s_used, s_fp;
  logic [4:0]      s_idx [NSRC];
  logic [XLEN-1:0] s_data [NSRC];
  logic [NSRC*5-1:0]    E_src_idx;
  logic [NSRC*XLEN-1:0] E_src_data;
  logic            M_wb_en, M_rd_fp, M_fwd_ok;
  logic [4:0]      M_rd_idx;
  logic [XLEN-1:0] M_data;
  logic            W_wb_en, W_rd_fp;
  logic [4:0]      W_rd_idx;
  logic [XLEN-1:0] W_data;
  logic            L_valid, L_rd_fp;
  logic [4:0]      L_rd_idx;
  logic [XLEN-1:0] L_data;

  logic [NSRC*XLEN-1:0] src_out;
  logic                 stall, sb_empty, err;
  logic [2:0]           out_cnt;

  always_comb begin
    E_src_idx  = '0;
    E_src_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      E_src_idx[k*5 +: 5]     = s_idx[k];
      E_src_data[k*XLEN +: XLEN] = s_data[k];
    end
  end

  fwd_sb_ctlr #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC), .MAX_OUT(MAXO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_E_valid(E_valid), .i_E_src_used(s_used), .i_E_src_fp(s_fp),
    .i_E_src_idx(E_src_idx), .i_E_src_data(E_src_data),
    .i_E_wb_en(E_wb_en), .i_E_rd_fp(E_rd_fp), .i_E_rd_idx(E_rd_idx),
    .i_E_long(E_long), .i_flush(flush),
    .i_M_wb_en(M_wb_en), .i_M_rd_fp(M_rd_fp), .i_M_rd_idx(M_rd_idx),
    .i_M_fwd_ok(M_fwd_ok), .i_M_fwd_data(M_data),
    .i_W_wb_en(W_wb_en), .i_W_rd_fp(W_rd_fp), .i_W_rd_idx(W_rd_idx),
    .i_W_wb_data(W_data),
    .i_L_valid(L_valid), .i_L_rd_fp(L_rd_fp), .i_L_rd_idx(L_rd_idx),
    .i_L_data(L_data),
    .o_src_data(src_out), .o_stall(stall), .o_out_cnt(out_cnt),
    .o_sb_empty(sb_empty), .o_err(err)
  );

  // Reference model: set of pending long-op destinations, count and error flag.
  bit mbusy [2][NREG];
  int mcnt;
  bit merr;

  int checks = 0;
  int errors = 0;

  function automatic bit same_reg(bit fa, int ia, bit fb, int ib);
    return (fa == fb) && (ia == ib) && !(fa == 1'b0 && ia == 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_src(int k);
    if (!s_used[k]) return s_data[k];
    if (L_valid && same_reg(L_rd_fp, L_rd_idx, s_fp[k], s_idx[k])) return L_data;
    if (M_wb_en && same_reg(M_rd_fp, M_rd_idx, s_fp[k], s_idx[k])) return M_data;
    if (W_wb_en && same_reg(W_rd_fp, W_rd_idx, s_fp[k], s_idx[k])) return W_data;
    return s_data[k];
  endfunction

  function automatic bit l_completes();
    return L_valid && !(L_rd_fp == 1'b0 && L_rd_idx == 0) && mbusy[L_rd_fp][L_rd_idx];
  endfunction

  function automatic bit exp_stall();
    if (!E_valid) return 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (s_used[k] && !(s_fp[k] == 1'b0 && s_idx[k] == 0)) begin
        if (mbusy[s_fp[k]][s_idx[k]] &&
            !(L_valid && same_reg(L_rd_fp, L_rd_idx, s_fp[k], s_idx[k]))) return 1'b1;
        if (M_wb_en && !M_fwd_ok && same_reg(M_rd_fp, M_rd_idx, s_fp[k], s_idx[k])) return 1'b1;
      end
    end
    if (E_wb_en && !(E_rd_fp == 1'b0 && E_rd_idx == 0) && mbusy[E_rd_fp][E_rd_idx] &&
        !(L_valid && same_reg(L_rd_fp, L_rd_idx, E_rd_fp, E_rd_idx))) return 1'b1;
    if (E_long && mcnt == MAXO && !l_completes()) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    E_valid = 0; E_wb_en = 0; E_rd_fp = 0; E_rd_idx = 0; E_long = 0; flush = 0;
    s_used = '0; s_fp = '0;
    for (int k = 0; k < NSRC; k++) begin s_idx[k] = '0; s_data[k] = '0; end
    M_wb_en = 0; M_rd_fp = 0; M_rd_idx = 0; M_fwd_ok = 1; M_data = '0;
    W_wb_en = 0; W_rd_fp = 0; W_rd_idx = 0; W_data = '0;
    L_valid = 0; L_rd_fp = 0; L_rd_idx = 0; L_data = '0;
  endtask

  task automatic model_clear();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NREG; r++) mbusy[f][r] = 1'b0;
    mcnt = 0;
    merr = 1'b0;
  endtask

  // Advance one clock; the model takes the same inputs the DUT sees at the edge.
  task automatic step();
    bit st, do_clr, do_err, do_set;
    bit lf, ef;
    int li, ei;
    st = exp_stall();
    lf = L_rd_fp; li = L_rd_idx; ef = E_rd_fp; ei = E_rd_idx;
    do_clr = 0; do_err = 0; do_set = 0;
    if (L_valid && !(lf == 1'b0 && li == 0)) begin
      if (mbusy[lf][li]) do_clr = 1; else do_err = 1;
    end
    if (E_valid && !st && !flush && E_long && E_wb_en && !(ef == 1'b0 && ei == 0)) do_set = 1;
    @(posedge clk);
    #1;
    if (do_clr) begin mbusy[lf][li] = 1'b0; mcnt--; end
    if (do_err) merr = 1'b1;
    if (do_set) begin mbusy[ef][ei] = 1'b1; mcnt++; end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic issue_long(bit fp, int idx);
    idle();
    E_valid = 1; E_long = 1; E_wb_en = 1; E_rd_fp = fp; E_rd_idx = 5'(idx);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", out_cnt); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", sb_empty); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    E_valid = 1; s_used[0] = 1; s_idx[0] = 5; s_data[0] = 32'h99;
    M_wb_en = 1; M_rd_idx = 5; M_fwd_ok = 1; M_data = 32'h11;
    W_wb_en = 1; W_rd_idx = 5; W_data = 32'h22;
    #1;
    checks++; if (src_out[31:0] !== 32'h11) begin errors++; $display("FAIL fwd_m got %h want 11", src_out[31:0]); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_m_stall got %b want 0", stall); end
    M_wb_en = 0; #1;
    checks++; if (src_out[31:0] !== 32'h22) begin errors++; $display("FAIL fwd_w got %h want 22", src_out[31:0]); end
    W_wb_en = 0; #1;
    checks++; if (src_out[31:0] !== 32'h99) begin errors++; $display("FAIL fwd_rf got %h want 99", src_out[31:0]); end
    M_wb_en = 1; M_fwd_ok = 0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use got %b want 1", stall); end
    step();
  endtask

  task automatic test_long_raw();
    do_reset();
    issue_long(1, 3); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL long_issue_stall got %b want 0", stall); end
    step();
    idle(); E_valid = 1; s_used[0] = 1; s_fp[0] = 1; s_idx[0] = 3; s_data[0] = 32'h5; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_long_stall got %b want 1", stall); end
    checks++; if (out_cnt !== 3'd1) begin errors++; $display("FAIL raw_long_cnt got %0d want 1", out_cnt); end
    step();
    L_valid = 1; L_rd_fp = 1; L_rd_idx = 3; L_data = 32'hABCD; #1;
    checks++; if (src_out[31:0] !== 32'hABCD) begin errors++; $display("FAIL l_fwd got %h want abcd", src_out[31:0]); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL l_fwd_stall got %b want 0", stall); end
    step();
    L_valid = 0; #1;
    checks++; if (out_cnt !== 3'd0) begin errors++; $display("FAIL l_clear_cnt got %0d want 0", out_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL l_clear_stall got %b want 0", stall); end
  endtask

  task automatic test_full();
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue_long(0, r); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_fill_stall x%0d got %b want 0", r, stall); end
      step();
    end
    issue_long(0, 8); #1;
    checks++; if (out_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d want 4", out_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b want 1", stall); end
    step();
    L_valid = 1; L_rd_idx = 2; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_l_stall got %b want 0", stall); end
    step();
    idle(); #1;
    checks++; if (out_cnt !== 3'd4) begin errors++; $display("FAIL full_swap_cnt got %0d want 4", out_cnt); end
  endtask

  task automatic test_waw_flush();
    do_reset();
    issue_long(0, 7); step();
    idle(); E_valid = 1; E_wb_en = 1; E_rd_idx = 7; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b want 1", stall); end
    step();
    issue_long(0, 9); flush = 1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
    step();
    idle(); E_valid = 1; s_used[1] = 1; s_idx[1] = 9; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_nobusy got %b want 0", stall); end
    checks++; if (out_cnt !== 3'd1) begin errors++; $display("FAIL flush_cnt got %0d want 1", out_cnt); end
    idle(); E_valid = 1; E_wb_en = 1; E_rd_idx = 7; L_valid = 1; L_rd_idx = 7; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_release got %b want 0", stall); end
    step();
    idle(); #1;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL waw_empty got %b want 1", sb_empty); end
  endtask

  task automatic test_x0_err();
    do_reset();
    E_valid = 1; s_used[0] = 1; s_idx[0] = 0; s_data[0] = 32'h1234;
    s_used[2] = 1; s_fp[2] = 1; s_idx[2] = 0; s_data[2] = 32'h7;
    M_wb_en = 1; M_rd_idx = 0; M_data = 32'hFFFF;
    W_wb_en = 1; W_rd_fp = 1; W_rd_idx = 0; W_data = 32'h3C;
    L_valid = 1; L_rd_idx = 0;
    #1;
    checks++; if (src_out[31:0] !== 32'h1234) begin errors++; $display("FAIL x0_src got %h want 1234", src_out[31:0]); end
    checks++; if (src_out[95:64] !== 32'h3C) begin errors++; $display("FAIL f0_src got %h want 3c", src_out[95:64]); end
    step();
    issue_long(0, 0); #1; step();
    idle(); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL x0_err got %b want 0", err); end
    checks++; if (out_cnt !== 3'd0) begin errors++; $display("FAIL x0_cnt got %0d want 0", out_cnt); end
    L_valid = 1; L_rd_fp = 1; L_rd_idx = 9; step();
    idle(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
    step(); step(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_cross_file();
    do_reset();
    E_valid = 1; s_used[1] = 1; s_idx[1] = 4; s_data[1] = 32'h44;
    M_wb_en = 1; M_rd_fp = 1; M_rd_idx = 4; M_fwd_ok = 0; M_data = 32'h55;
    #1;
    checks++; if (src_out[63:32] !== 32'h44) begin errors++; $display("FAIL cross_src got %h want 44", src_out[63:32]); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cross_stall got %b want 0", stall); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_long(0, 1); step();
    issue_long(0, 2); step();
    issue_long(1, 5); step();
    idle(); #1;
    checks++; if (out_cnt !== 3'd3) begin errors++; $display("FAIL mid_cnt got %0d want 3", out_cnt); end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", sb_empty); end
    checks++; if (out_cnt !== 3'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", out_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    L_valid = 1; L_rd_idx = 1; step();
    idle(); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL late_l_err got %b want 1", err); end
    checks++; if (out_cnt !== 3'd0) begin errors++; $display("FAIL late_l_cnt got %0d want 0", out_cnt); end
  endtask

  task automatic test_random();
    int pend [$];
    int pick;
    logic [XLEN-1:0] want;
    bit st;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      E_valid = ($urandom_range(0, 9) < 8);
      for (int k = 0; k < NSRC; k++) begin
        s_used[k] = $urandom_range(0, 1);
        s_fp[k]   = $urandom_range(0, 1);
        s_idx[k]  = 5'($urandom_range(0, 7));
        s_data[k] = $urandom;
      end
      E_wb_en  = $urandom_range(0, 1);
      E_rd_fp  = $urandom_range(0, 1);
      E_rd_idx = 5'($urandom_range(0, 7));
      E_long   = ($urandom_range(0, 9) < 4);
      flush    = ($urandom_range(0, 9) == 0);
      M_wb_en  = $urandom_range(0, 1);
      M_rd_fp  = $urandom_range(0, 1);
      M_rd_idx = 5'($urandom_range(0, 7));
      M_fwd_ok = ($urandom_range(0, 9) < 7);
      M_data   = $urandom;
      W_wb_en  = $urandom_range(0, 1);
      W_rd_fp  = $urandom_range(0, 1);
      W_rd_idx = 5'($urandom_range(0, 7));
      W_data   = $urandom;
      L_valid  = ($urandom_range(0, 99) < 35);
      L_data   = $urandom;
      pend.delete();
      for (int f = 0; f < 2; f++)
        for (int r = 0; r < NREG; r++)
          if (mbusy[f][r]) pend.push_back(f * NREG + r);
      if (pend.size() > 0 && $urandom_range(0, 99) < 85) begin
        pick = pend[$urandom_range(0, pend.size() - 1)];
        L_rd_fp  = (pick >= NREG);
        L_rd_idx = 5'(pick % NREG);
      end else begin
        L_rd_fp  = $urandom_range(0, 1);
        L_rd_idx = 5'($urandom_range(0, 7));
      end
      #1;
      for (int k = 0; k < NSRC; k++) begin
        want = exp_src(k);
        checks++;
        if (src_out[k*XLEN +: XLEN] !== want) begin
          errors++;
          $display("FAIL rnd_src%0d cyc %0d got %h want %h", k, cyc, src_out[k*XLEN +: XLEN], want);
        end
      end
      st = exp_stall();
      checks++; if (stall !== st) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", cyc, stall, st); end
      checks++; if (out_cnt !== 3'(mcnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", cyc, out_cnt, mcnt); end
      checks++; if (sb_empty !== (mcnt == 0)) begin errors++; $display("FAIL rnd_empty cyc %0d got %b want %b", cyc, sb_empty, mcnt == 0); end
      checks++; if (err !== merr) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", cyc, err, merr); end
      step();
    end
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_fwd_priority();
    test_long_raw();
    test_full();
    test_waw_flush();
    test_x0_err();
    test_cross_file();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_sb_ctlr.md
Name: fwd_sb_ctlr

Overview:
- Next-generation E-stage operand forwarding and hazard controller for the integer/FP pipeline.
- Generalises M/W bypass to NSRC sources (e.g. rs3 for fused FP ops) across two register files (int, fp).
- Adds a registered scoreboard for long-latency writers (loads, div, FP div/sqrt) that complete on a separate L port.
- Produces forwarded operands plus a single stall request (RAW, WAW, load-use, scoreboard-full).

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, registers per file; index width is REG_IDX_W = 5.
- NSRC, 3, source operands resolved in parallel.
- MAX_OUT, 4, maximum outstanding long-latency ops.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_E_valid  in  1  E-stage instruction valid
- i_E_src_used  in  NSRC  source k is read
- i_E_src_fp  in  NSRC  source k comes from the fp file
- i_E_src_idx  in  NSRC*5  source register indices
- i_E_src_data  in  NSRC*XLEN  register-file read data
- i_E_wb_en  in  1  E instruction writes rd
- i_E_rd_fp  in  1  rd is in the fp file
- i_E_rd_idx  in  5  rd index
- i_E_long  in  1  E instruction is long-latency (result arrives on L)
- i_flush  in  1  kill the E instruction this cycle
- i_M_wb_en, i_M_rd_fp, i_M_rd_idx  in  1/1/5  M-stage writer
- i_M_fwd_ok  in  1  M result is available (0 for load in M)
- i_M_fwd_data  in  XLEN  M result, already wb_sel-muxed
- i_W_wb_en, i_W_rd_fp, i_W_rd_idx  in  1/1/5  W-stage writer
- i_W_wb_data  in  XLEN  W result
- i_L_valid, i_L_rd_fp, i_L_rd_idx  in  1/1/5  long-op completion
- i_L_data  in  XLEN  long-op result
- o_src_data  out  NSRC*XLEN  resolved operands (combinational)
- o_stall  out  1  hold F/D/E and bubble M
- o_out_cnt  out  clog2(MAX_OUT+1)  outstanding long ops
- o_sb_empty  out  1  no long op pending (used by fence and CSR)
- o_err  out  1  sticky: completion on a non-busy register

Behaviour:
- State: busy[2][NREG] plus out_cnt.
- Reset clears all state: o_out_cnt=0, o_sb_empty=1, o_err=0.
- Int x0 rules:
  - Never set busy.
  - Never matched as a source; its operand is always i_E_src_data.
  - Never matched as a destination.
- fp f0 is an ordinary register.
- Match definition: a writer matches source k when:
  - src_used[k] = 1,
  - writer fp == src_fp[k],
  - writer index == src_idx[k],
  - the writer's enable is set.
- Per-source operand priority: L > M > W > RF.
  - Rationale: WAW stalling guarantees any pending long op is younger than M and W writers of the same register.
- Stall sources (o_stall = i_E_valid & OR of these):
  - (a) RAW-long: source k matches busy and there is no same-cycle L completion for it.
  - (b) Load-use: M match with i_M_fwd_ok=0.
  - (c) WAW: i_E_wb_en and rd is busy, not completing this cycle.
  - (d) Full: i_E_long and out_cnt==MAX_OUT, not completing this cycle.
- Issue: issue = i_E_valid & ~o_stall & ~i_flush.
  - If issue & i_E_long & i_E_wb_en & rd not x0, set busy[rd_fp][rd] at the next edge and increment out_cnt.
- Completion: i_L_valid on a busy register clears it at the next edge and decrements out_cnt.
  - i_L_valid on a non-busy register: no count change, o_err is set (sticky until reset).
  - i_L_valid completing x0: ignored, no error.
- Simultaneous issue and completion:
  - Same register: ends busy; out_cnt unchanged.
  - Different registers: out_cnt unchanged.
- i_flush with a long op in E: nothing is recorded; in-flight entries are never flushed.
- Latency:
  - o_src_data and o_stall are combinational from inputs and current state.
  - Scoreboard updates take effect one cycle after issue or completion.
- Reset asserted mid-operation: scoreboard cleared immediately; late L completions after reset set o_err.

Decomposition:
- fwd_pkg holds:
  - REG_IDX_W, RF_INT=0, RF_FP=1;
  - a writer_t struct {wb_en, fp, idx};
  - a function match(writer_t, fp, idx) with the x0 rule built in.
- One sub-module, fwd_src_resolve: per-source priority mux plus RAW and load-use hazard bits.
  - Instantiated NSRC times by generate.
- The scoreboard, counter and stall OR remain in the top module.

Test Plan:
- Reset, then E reads x5 with M writing x5 (fwd_ok=1, data 0x11) and W writing x5 (0x22) -> src=0x11, no stall.
- Long load to f3 issued; next cycle E reads f3 -> o_stall=1 and out_cnt=1. L completes f3 with 0xABCD in the same cycle -> src=0xABCD, stall=0, busy cleared next edge.
- Four long ops issued to x1..x4 -> out_cnt=4; fifth long op stalls; with L completing x2 that cycle -> fifth op issues and out_cnt stays 4.
- E writes x7 while x7 is busy -> WAW stall until L on x7; the i_flush cycle sets no busy bit.
- src x0 with M writing x0 with 0xFFFF -> src=i_E_src_data. L completion on a non-busy f9 -> o_err=1, stays 1.
- Source int x4 while M writes f4 (fp) -> no forward. Reset asserted with out_cnt=3 -> o_sb_empty=1 asynchronously.
